// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sin/cos engine (angles in Q9.23 degrees).
// Holds the FSM state encoding, the CORDIC gain and the arctangent table.
package cordic_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FOLD, ST_ITER, ST_DONE} state_t;

    localparam int IDX_W  = 5;
    localparam int K_Q230 = 652032874;
    localparam int DEG90  = 754974720;
    localparam int DEG180 = 1509949440;

    // round(atan(2^-i) in degrees * 2^23); indices past the table return 0
    function automatic logic [31:0] atan_deg(input logic [IDX_W-1:0] i);
        logic [31:0] v;
        case (i)
            5'd0:  v = 32'd377487360;
            5'd1:  v = 32'd222843801;
            5'd2:  v = 32'd117744544;
            5'd3:  v = 32'd59768969;
            5'd4:  v = 32'd30000467;
            5'd5:  v = 32'd15014858;
            5'd6:  v = 32'd7509261;
            5'd7:  v = 32'd3754860;
            5'd8:  v = 32'd1877459;
            5'd9:  v = 32'd938733;
            5'd10: v = 32'd469367;
            5'd11: v = 32'd234683;
            5'd12: v = 32'd117342;
            5'd13: v = 32'd58671;
            5'd14: v = 32'd29335;
            5'd15: v = 32'd14668;
            5'd16: v = 32'd7334;
            5'd17: v = 32'd3667;
            5'd18: v = 32'd1833;
            5'd19: v = 32'd917;
            5'd20: v = 32'd458;
            5'd21: v = 32'd229;
            5'd22: v = 32'd115;
            5'd23: v = 32'd57;
            5'd24: v = 32'd29;
            5'd25: v = 32'd14;
            5'd26: v = 32'd7;
            5'd27: v = 32'd4;
            5'd28: v = 32'd2;
            5'd29: v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup by iteration index; zero latency, no flow control.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [AW-1:0]    atan_o
);

    assign atan_o = AW'(atan_deg(idx_i));

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: angle (Q9.23 deg) -> cos/sin (Q2.30), one micro-rotation per clock.
// Latency: done pulses ITER+2 cycles after accept (2 on range error); start is ignored while not idle.
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int ITER = 24,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [AW-1:0] angle,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic signed [DW-1:0] cos_o,
    output logic signed [DW-1:0] sin_o
);

    localparam int XW = DW + 2;
    localparam int ZW = AW + 1;

    localparam logic signed [ZW-1:0] P90  = ZW'(DEG90);
    localparam logic signed [ZW-1:0] N90  = -P90;
    localparam logic signed [ZW-1:0] P180 = ZW'(DEG180);
    localparam logic signed [ZW-1:0] N180 = -P180;
    localparam logic signed [XW:0]   O_MAX = {{(XW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW:0]   O_MIN = {{(XW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    state_t                  state_q;
    logic signed [AW-1:0]    ang_q;
    logic signed [XW-1:0]    x_q, y_q, x_d, y_d, x_sh, y_sh;
    logic signed [ZW-1:0]    z_q, z_d, ang_z, fold_z, atan_z;
    logic [IDX_W-1:0]        cnt_q;
    logic                    neg_q, rng_q, fold_neg, fold_rng;
    logic                    busy_q, done_q, err_q;
    logic signed [DW-1:0]    cos_q, sin_q;
    logic signed [XW:0]      x_out, y_out;
    logic [AW-1:0]           atan_w;

    cordic_atan_rom #(.AW(AW)) u_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_w)
    );

    function automatic logic signed [DW-1:0] sat(input logic signed [XW:0] v);
        if (v > O_MAX)      return O_MAX[DW-1:0];
        else if (v < O_MIN) return O_MIN[DW-1:0];
        else                return v[DW-1:0];
    endfunction

    assign ang_z  = {ang_q[AW-1], ang_q};
    assign atan_z = $signed({1'b0, atan_w});

    // Fold into [-90, 90]; a 180-degree rotation is undone by negating the result
    always_comb begin
        fold_rng = (ang_z > P180) || (ang_z < N180);
        fold_neg = 1'b0;
        fold_z   = ang_z;
        if (ang_z > P90) begin
            fold_z   = ang_z - P180;
            fold_neg = 1'b1;
        end else if (ang_z < N90) begin
            fold_z   = ang_z + P180;
            fold_neg = 1'b1;
        end
    end

    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!z_q[ZW-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_z;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_z;
        end
    end

    always_comb begin
        x_out = {x_q[XW-1], x_q};
        y_out = {y_q[XW-1], y_q};
        if (neg_q) begin
            x_out = -x_out;
            y_out = -y_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ang_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rng_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ang_q   <= angle;
                        busy_q  <= 1'b1;
                        state_q <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    x_q   <= XW'(K_Q230);
                    y_q   <= '0;
                    z_q   <= fold_z;
                    neg_q <= fold_neg;
                    rng_q <= fold_rng;
                    cnt_q <= '0;
                    if (fold_rng) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(ITER - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    err_q   <= rng_q;
                    cos_q   <= rng_q ? '0 : sat(x_out);
                    sin_q   <= rng_q ? '0 : sat(y_out);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule
